// File: rtl/banked_word_memory.sv
// rtl/banked_word_memory.sv - byte-lane banked word memory with pipelined read responses.
// Optional power-on zero fill is enabled by defining BANKED_WORD_MEMORY_INIT_CLEAR_EN.
module banked_word_memory #(
   parameter int DATA_DEPTH   = 1024,
   parameter int LANES        = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [LANES-1:0]              req_be,
   input  logic [$clog2(DATA_DEPTH)-1:0] req_addr,
   input  logic [8*LANES-1:0]            req_wdata,
   output logic                          rsp_valid,
   output logic [8*LANES-1:0]            rsp_rdata,
   output logic                          busy
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int DW = 8 * LANES;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DATA_DEPTH);

   logic             accept;
   logic             rd_en;
   logic             in_range;
   logic             wr_hit;
   logic [AW-1:0]    bank_addr;
   logic [LANES-1:0] bank_we;
   logic [DW-1:0]    bank_wdata;
   logic [DW-1:0]    bank_rdata;

   // Out-of-range requests never touch storage; the address width can exceed the depth.
   assign in_range = {1'b0, req_addr} < DEPTH_W;
   assign accept   = req_valid & req_ready;
   assign rd_en    = accept & ~req_we;
   assign wr_hit   = req_valid & req_we & in_range;

`ifdef BANKED_WORD_MEMORY_INIT_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      busy       = 1'b0;
      req_ready  = 1'b1;
      bank_addr  = req_addr;
      bank_we    = wr_hit ? req_be : '0;
      bank_wdata = req_wdata;
      if (state_q == ST_CLEAR) begin
         busy       = 1'b1;
         req_ready  = 1'b0;
         bank_addr  = clr_addr_q;
         bank_we    = '1;
         bank_wdata = '0;
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_READY;
         end
      end
   end
`else
   assign busy       = 1'b0;
   assign req_ready  = 1'b1;
   assign bank_addr  = req_addr;
   assign bank_we    = wr_hit ? req_be : '0;
   assign bank_wdata = req_wdata;
`endif

   // Storage is deliberately outside the reset domain so contents survive rst_n.
   for (genvar i = 0; i < LANES; i++) begin : g_bank
      logic [7:0] mem [DATA_DEPTH];

      always_ff @(posedge clk) begin
         if (bank_we[i]) begin
            mem[bank_addr] <= bank_wdata[8*i +: 8];
         end
      end

      assign bank_rdata[8*i +: 8] = mem[req_addr];
   end

   logic [READ_LATENCY-1:0] pipe_vld_q;
   logic [DW-1:0]           pipe_data_q [READ_LATENCY];

   // Data stages only advance behind a valid, so the last stage holds between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_data_q[s] <= '0;
         end
      end else begin
         pipe_vld_q[0] <= rd_en;
         if (rd_en) begin
            pipe_data_q[0] <= in_range ? bank_rdata : '0;
         end
         for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_vld_q[s] <= pipe_vld_q[s-1];
            if (pipe_vld_q[s-1]) begin
               pipe_data_q[s] <= pipe_data_q[s-1];
            end
         end
      end
   end

   assign rsp_valid = pipe_vld_q[READ_LATENCY-1];
   assign rsp_rdata = pipe_data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_banked_word_memory.sv
// tb/tb_banked_word_memory.sv - scoreboard bench for banked_word_memory.
module tb_banked_word_memory;

`ifdef BANKED_WORD_MEMORY_INIT_CLEAR_EN
   localparam int DEPTH = 16;
`else
   localparam int DEPTH = 1000;
`endif
   localparam int LAT = 2;
   localparam int AW  = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [3:0]    req_be = '0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] exp_data_q [$];
   int          exp_cyc_q [$];
   logic [31:0] last_exp = '0;

   banked_word_memory #(
      .DATA_DEPTH  (DEPTH),
      .LANES       (4),
      .READ_LATENCY(LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_be   (req_be),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every response must match the head of the scoreboard, in the expected cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_exp = '0;
      end else if (rsp_valid) begin
         if (exp_data_q.size() == 0) begin
            check("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            logic [31:0] ed;
            int          ec;
            ed = exp_data_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("rsp_rdata", rsp_rdata, ed);
            check("rsp_cycle", 32'(cyc), 32'(ec));
            last_exp = ed;
         end
      end else begin
         check("rsp_rdata_hold", rsp_rdata, last_exp);
      end
   end

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_be    = '0;
      req_wdata = '0;
   endtask

   task automatic issue(input logic we, input logic [3:0] be, input int addr,
                        input logic [31:0] d, input logic [31:0] exp);
      req_valid = 1'b1;
      req_we    = we;
      req_be    = be;
      req_addr  = AW'(addr);
      req_wdata = d;
      if (!we) begin
         exp_data_q.push_back(exp);
         exp_cyc_q.push_back(cyc + LAT);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 20 && exp_data_q.size() != 0; i++) @(negedge clk);
      check("drain_outstanding", 32'(exp_data_q.size()), 32'd0);
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         check("ready_while_busy", 32'(req_ready), 32'd0);
      end
      check("ready_after_clear", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      n = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
`ifdef BANKED_WORD_MEMORY_INIT_CLEAR_EN
      wait_clear(n);
      check("init_busy_cycles", 32'(n), 32'(DEPTH));
      for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'h0, a, 32'h0, 32'h0);
      drain();
`else
      @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("ready_idle", 32'(req_ready), 32'd1);
`endif
      // Full write, then read on the very next cycle.
      issue(1'b1, 4'b1111, 5, 32'hA1B2C3D4, 32'h0);
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hA1B2C3D4);
      drain();
      // Partial lane write, then all-zero byte enable.
      issue(1'b1, 4'b0101, 5, 32'h11223344, 32'h0);
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hA122C344);
      issue(1'b1, 4'b0000, 5, 32'hFFFFFFFF, 32'h0);
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hA122C344);
      drain();
      // Preload and stream four reads without gaps.
      for (int a = 0; a < 4; a++) issue(1'b1, 4'b1111, a, 32'h10 + 32'(a), 32'h0);
      issue(1'b0, 4'b0000, 0, 32'h0, 32'h10);
      issue(1'b0, 4'b0000, 1, 32'h0, 32'h11);
      issue(1'b0, 4'b0000, 2, 32'h0, 32'h12);
      issue(1'b0, 4'b0000, 3, 32'h0, 32'h13);
      drain();
      // Read followed by write to the same address returns the old word.
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hA122C344);
      issue(1'b1, 4'b1111, 5, 32'hDEADBEEF, 32'h0);
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hDEADBEEF);
      drain();
`ifndef BANKED_WORD_MEMORY_INIT_CLEAR_EN
      issue(1'b1, 4'b1111, 999, 32'h12345678, 32'h0);
      issue(1'b1, 4'b1111, 1000, 32'hFFFFFFFF, 32'h0);
      issue(1'b0, 4'b0000, 1000, 32'h0, 32'h0);
      issue(1'b0, 4'b0000, 999, 32'h0, 32'h12345678);
      issue(1'b0, 4'b0000, 1023, 32'h0, 32'h0);
      drain();
`endif
      // Reset while a read is in flight: its response must never appear.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(5);
      @(posedge clk);
      #1;
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
      check("flush_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
`ifdef BANKED_WORD_MEMORY_INIT_CLEAR_EN
      wait_clear(n);
      check("reclear_busy_cycles", 32'(n), 32'(DEPTH));
`endif
      repeat (4) @(negedge clk);
      check("post_flush_rsp_rdata", rsp_rdata, 32'd0);
`ifdef BANKED_WORD_MEMORY_INIT_CLEAR_EN
      issue(1'b0, 4'b0000, 5, 32'h0, 32'h0);
      issue(1'b1, 4'b1111, 5, 32'hCAFEF00D, 32'h0);
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hCAFEF00D);
      drain();
      // Reset pulsed at cycle 8 of initialisation restarts the full sweep.
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("partial_busy", 32'(busy), 32'd1);
      end
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_clear(n);
      check("restart_busy_cycles", 32'(n), 32'(DEPTH));
      for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'h0, a, 32'h0, 32'h0);
      drain();
`else
      issue(1'b0, 4'b0000, 5, 32'h0, 32'hDEADBEEF);
      drain();
`endif
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
